// File: rtl/if_pc_pkg.sv
// ----------------------------------------------------------------------------
// if_pc_pkg
// Shared constants for the MIPS instruction-fetch program counter:
//   - IF_NB_ADDR / IF_NB_INST : default address and instruction widths
//   - IF_ALIGN_LSB            : address bits that must be zero for a word
//   - IF_WORD_ALIGN_MASK      : full-width mask that clears the byte offset
//   - IF_RESET_VECTOR         : default PC value after reset
// ----------------------------------------------------------------------------
package if_pc_pkg;

    localparam int unsigned IF_NB_ADDR = 32;
    localparam int unsigned IF_NB_INST = 32;

    // Byte-offset bits within a 32-bit instruction word.
    localparam logic [1:0] IF_ALIGN_LSB = 2'b11;

    localparam logic [IF_NB_ADDR-1:0] IF_WORD_ALIGN_MASK = ~IF_NB_ADDR'(IF_ALIGN_LSB);

    localparam logic [IF_NB_ADDR-1:0] IF_RESET_VECTOR = 32'h0000_0000;

endpackage : if_pc_pkg

// File: rtl/if_pc.sv
// ----------------------------------------------------------------------------
// if_pc
// Program-counter register of the IF stage. Loads the next-PC value on each
// enabled rising edge, holds it when the enable is low (stall / debug halt),
// and returns to RESET_VECTOR asynchronously on reset.
//
// Optional feature (macro IF_PC_ALIGN_CHECK_EN): loaded PCs have bits [1:0]
// forced to zero and a registered o_misaligned flag reports whether the last
// loaded value had a non-zero byte offset.
//
// Ports:
//   i_clk         clock, rising edge
//   i_reset       asynchronous active-high reset
//   i_enable      1 = load i_pc at the edge, 0 = hold
//   i_pc          next-PC value from the next-PC mux
//   o_pc          current PC, straight from the register
//   o_misaligned  registered misalignment flag (IF_PC_ALIGN_CHECK_EN only)
// ----------------------------------------------------------------------------
module if_pc
    import if_pc_pkg::*;
#(
    parameter int unsigned             NB_ADDR      = IF_NB_ADDR,
    parameter logic [NB_ADDR-1:0]      RESET_VECTOR = NB_ADDR'(IF_RESET_VECTOR)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic [NB_ADDR-1:0] i_pc,
`ifdef IF_PC_ALIGN_CHECK_EN
    output logic               o_misaligned,
`endif
    output logic [NB_ADDR-1:0] o_pc
);

    logic [NB_ADDR-1:0] pc_q;
    logic [NB_ADDR-1:0] pc_d;

`ifdef IF_PC_ALIGN_CHECK_EN
    // Width-generic word mask: clears only the byte-offset bits.
    localparam logic [NB_ADDR-1:0] ALIGN_MASK = ~NB_ADDR'(IF_ALIGN_LSB);

    logic misaligned_q;
    logic misaligned_d;
`endif

    // Next-state: hold by default, take the upstream next-PC when enabled.
    always_comb begin
        pc_d = pc_q;
`ifdef IF_PC_ALIGN_CHECK_EN
        misaligned_d = misaligned_q;
        if (i_enable) begin
            pc_d         = i_pc & ALIGN_MASK;
            misaligned_d = |(i_pc & ~ALIGN_MASK);
        end
`else
        if (i_enable) begin
            pc_d = i_pc;
        end
`endif
    end

    // PC register; reset branch is taken whenever i_reset is high, so unknown
    // enable/data cannot disturb the reset value.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

`ifdef IF_PC_ALIGN_CHECK_EN
    // Misalignment flag register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign o_misaligned = misaligned_q;
`endif

    assign o_pc = pc_q;

endmodule : if_pc

// File: tb/tb_if_pc.sv
// ----------------------------------------------------------------------------
// tb_if_pc
// Self-checking bench for if_pc. Two instances share the stimulus: one with
// the default reset vector, one with 0xBFC00000. Expected values come from a
// simple behavioural model of the PC register kept in the bench.
// ----------------------------------------------------------------------------
module tb_if_pc;

    localparam int unsigned NB = 32;
    localparam logic [NB-1:0] RV0 = 32'h0000_0000;
    localparam logic [NB-1:0] RV1 = 32'hBFC0_0000;

    logic          clk;
    logic          rst;
    logic          en;
    logic [NB-1:0] pc_in;
    logic [NB-1:0] pc0;
    logic [NB-1:0] pc1;
    logic          mis0;
    logic          mis1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state
    logic [NB-1:0] exp0;
    logic [NB-1:0] exp1;
    logic          exp_mis;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_pc #(.NB_ADDR(NB), .RESET_VECTOR(RV0)) dut0 (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_pc        (pc_in),
`ifdef IF_PC_ALIGN_CHECK_EN
        .o_misaligned(mis0),
`endif
        .o_pc        (pc0)
    );

    if_pc #(.NB_ADDR(NB), .RESET_VECTOR(RV1)) dut1 (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_enable    (en),
        .i_pc        (pc_in),
`ifdef IF_PC_ALIGN_CHECK_EN
        .o_misaligned(mis1),
`endif
        .o_pc        (pc1)
    );

`ifndef IF_PC_ALIGN_CHECK_EN
    assign mis0 = 1'b0;
    assign mis1 = 1'b0;
`endif

    // Value the PC should hold after loading v.
    function automatic logic [NB-1:0] load_val(input logic [NB-1:0] v);
`ifdef IF_PC_ALIGN_CHECK_EN
        return {v[NB-1:2], 2'b00};
`else
        return v;
`endif
    endfunction

    function automatic logic load_mis(input logic [NB-1:0] v);
`ifdef IF_PC_ALIGN_CHECK_EN
        return (v[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc0"}, pc0, exp0);
        check({tag, ".pc1"}, pc1, exp1);
        check({tag, ".mis0"}, NB'(mis0), NB'(exp_mis));
        check({tag, ".mis1"}, NB'(mis1), NB'(exp_mis));
    endtask

    // One clock: drive at negedge, update model at posedge, sample 1 ns later.
    task automatic step(input string tag, input logic r, input logic e, input logic [NB-1:0] v);
        @(negedge clk);
        rst   = r;
        en    = e;
        pc_in = v;
        @(posedge clk);
        if (r) begin
            exp0    = RV0;
            exp1    = RV1;
            exp_mis = 1'b0;
        end else if (e) begin
            exp0    = load_val(v);
            exp1    = load_val(v);
            exp_mis = load_mis(v);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst   = 1'b0;
        en    = 1'bx;
        pc_in = 'x;
        #1;
        rst     = 1'b1;
        exp0    = RV0;
        exp1    = RV1;
        exp_mis = 1'b0;
        // Reset held ~20 ns with unknown enable/data.
        for (int k = 0; k < 4; k++) begin
            #5;
            check_all("reset_hold");
        end

        // Sequential loads after reset release.
        step("load4", 1'b0, 1'b1, 32'h0000_0004);
        step("load8", 1'b0, 1'b1, 32'h0000_0008);

        // Stall for three edges, then resume.
        step("load10", 1'b0, 1'b1, 32'h0000_0010);
        for (int k = 0; k < 3; k++) step("stall", 1'b0, 1'b0, 32'h0000_0020);
        step("resume20", 1'b0, 1'b1, 32'h0000_0020);

        // Asynchronous reset pulse between clock edges.
        step("load40", 1'b0, 1'b1, 32'h0000_0040);
        #2;
        rst = 1'b1;
        #1;
        exp0    = RV0;
        exp1    = RV1;
        exp_mis = 1'b0;
        check_all("async_rst");
        rst = 1'b0;
        #1;
        check_all("async_rel");

        // Odd address, then aligned load clears the flag.
        step("odd1", 1'b0, 1'b1, 32'h0000_0001);
        step("odd_hold", 1'b0, 1'b0, 32'h0000_0100);
        step("aligned", 1'b0, 1'b1, 32'h0000_0200);

        // Top of the address range.
        step("full", 1'b0, 1'b1, 32'hFFFF_FFFC);
        step("ones", 1'b0, 1'b1, 32'hFFFF_FFFF);
        step("wrap0", 1'b0, 1'b1, 32'h0000_0000);

        // Synchronous-style reset overriding a load in the same cycle.
        step("rst_vs_load", 1'b1, 1'b1, 32'h1234_5678);
        step("post_rst", 1'b0, 1'b1, 32'h0000_0004);

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            logic          r;
            logic          e;
            logic [NB-1:0] v;
            r = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 3) != 0);
            v = $urandom;
            if ($urandom_range(0, 1) == 0) v[1:0] = 2'b00;
            step("rand", r, e, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_if_pc
